pwm_capture_multi: RTL and testbench

//  Synthesizable N-channel PWM capture: measures high time and period of each input in clk cycles,

---
 rtl/pwm_capture_pkg.sv | 20 ++
 rtl/pwm_capture_chan.sv | 190 +++++++++++++++++++
 rtl/pwm_capture_multi.sv | 98 +++++++++
 tb/tb_pwm_capture_multi.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared types and helpers for the multi-channel PWM capture block.
// The per-channel FSM state enum and its width, plus a select-width helper
// that stays legal for a single-channel build.
package pwm_capture_pkg;

  localparam int STATE_W = 2;

  // WAIT: no reference rise yet, HIGH: input high, LOW: input low after a high
  typedef enum logic [STATE_W-1:0] {
    ST_WAIT = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } chan_state_e;

  // Width of a channel select; at least one bit so a 1-channel build has a port
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_capture_chan.sv
// One PWM capture channel: input synchronizer, registered edge detect,
// WAIT/HIGH/LOW measurement FSM with a saturating counter, idle timeout,
// and the published high/period pair with its strobe and sticky valid.
// Optional min/max high-time tracking when PWM_CAPTURE_MINMAX_EN is defined.
module pwm_capture_chan
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W       = 20,
  parameter int TIMEOUT     = 1_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] high_o,
  output logic [CNT_W-1:0] period_o,
`ifdef PWM_CAPTURE_MINMAX_EN
  output logic [CNT_W-1:0] hmin_o,
  output logic [CNT_W-1:0] hmax_o,
`endif
  output logic             stb_o,
  output logic             valid_o,
  output logic             timeout_o,
  output logic             level_o,
  output chan_state_e      state_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   level;
  logic                   edge_any;
  logic                   publish;
  logic                   tmo_hit;

  chan_state_e            state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_inc;
  logic [CNT_W-1:0]       hi_lat_q;
  logic [CNT_W-1:0]       idle_q;
  logic                   timeout_q;

  logic [CNT_W-1:0]       high_q;
  logic [CNT_W-1:0]       period_q;
  logic                   stb_q;
  logic                   valid_q;

  assign level    = sync_q[SYNC_STAGES-1];
  assign edge_any = rise_q | fall_q;
  // A publish is the rise that closes a full high+low cycle
  assign publish  = (state_q == ST_LOW) && rise_q;
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  // Fires once, on the TIMEOUT-th consecutive cycle without an edge
  assign tmo_hit  = !edge_any && !timeout_q && (idle_q == TMO_LAST);

  // Synchronizer chain for the raw asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
    end
  end

  // Registered rise/fall pulses on the synchronized level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      prev_q <= level;
      rise_q <= level & ~prev_q;
      fall_q <= ~level & prev_q;
    end
  end

  // Idle counter and sticky timeout flag; any edge restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else if (edge_any) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else if (tmo_hit) begin
      timeout_q <= 1'b1;
    end else if (!timeout_q) begin
      idle_q <= idle_q + 1'b1;
    end
  end

  // Measurement FSM with saturating cycle counter and high-time latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_WAIT;
      cnt_q    <= '0;
      hi_lat_q <= '0;
    end else if (tmo_hit) begin
      state_q <= ST_WAIT;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (rise_q) begin
            state_q <= ST_HIGH;
            cnt_q   <= CNT_ONE;
          end
        end
        ST_HIGH: begin
          cnt_q <= cnt_inc;
          if (fall_q) begin
            state_q  <= ST_LOW;
            hi_lat_q <= cnt_q;
          end
        end
        ST_LOW: begin
          if (rise_q) begin
            state_q <= ST_HIGH;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= ST_WAIT;
      endcase
    end
  end

  // Published pair, one-cycle strobe, sticky valid (publish beats clr)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_q   <= '0;
      period_q <= '0;
      stb_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else if (publish) begin
      high_q   <= hi_lat_q;
      period_q <= cnt_q;
      stb_q    <= 1'b1;
      valid_q  <= 1'b1;
    end else begin
      stb_q <= 1'b0;
      if (clr_i) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef PWM_CAPTURE_MINMAX_EN
  logic [CNT_W-1:0] hmin_q;
  logic [CNT_W-1:0] hmax_q;

  // Min/max of published high time; a publish alongside clr seeds both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hmin_q <= '1;
      hmax_q <= '0;
    end else if (publish) begin
      if (clr_i) begin
        hmin_q <= hi_lat_q;
        hmax_q <= hi_lat_q;
      end else begin
        if (hi_lat_q < hmin_q) hmin_q <= hi_lat_q;
        if (hi_lat_q > hmax_q) hmax_q <= hi_lat_q;
      end
    end else if (clr_i) begin
      hmin_q <= '1;
      hmax_q <= '0;
    end
  end

  assign hmin_o = hmin_q;
  assign hmax_o = hmax_q;
`endif

  assign high_o    = high_q;
  assign period_o  = period_q;
  assign stb_o     = stb_q;
  assign valid_o   = valid_q;
  assign timeout_o = timeout_q;
  assign level_o   = level;
  assign state_o   = state_q;

endmodule

// File: rtl/pwm_capture_multi.sv
// N-channel PWM capture: measures high time and period of each input in clk
// cycles and flags inputs that stop toggling. Holds the channel array, the
// clr fan-out and the registered read-back mux. chan_state exposes every
// channel FSM for observation.
// Optional feature macro: PWM_CAPTURE_MINMAX_EN adds rd_hmin/rd_hmax.
module pwm_capture_multi
  import pwm_capture_pkg::*;
#(
  parameter int  CHANNELS    = 4,
  parameter int  CNT_W       = 20,
  parameter int  TIMEOUT     = 1_000_000,
  parameter int  SYNC_STAGES = 2,
  localparam int SEL_W       = sel_width(CHANNELS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CHANNELS-1:0]           pwm_in,
  input  logic                          clr,
  input  logic [SEL_W-1:0]              rd_sel,
  output logic [CNT_W-1:0]              rd_high,
  output logic [CNT_W-1:0]              rd_period,
`ifdef PWM_CAPTURE_MINMAX_EN
  output logic [CNT_W-1:0]              rd_hmin,
  output logic [CNT_W-1:0]              rd_hmax,
`endif
  output logic [CHANNELS-1:0]           meas_stb,
  output logic [CHANNELS-1:0]           meas_valid,
  output logic [CHANNELS-1:0]           timeout,
  output logic [CHANNELS-1:0]           level,
  output logic [CHANNELS*STATE_W-1:0]   chan_state
);

  logic [CNT_W-1:0] high_w   [CHANNELS];
  logic [CNT_W-1:0] period_w [CHANNELS];
`ifdef PWM_CAPTURE_MINMAX_EN
  logic [CNT_W-1:0] hmin_w   [CHANNELS];
  logic [CNT_W-1:0] hmax_w   [CHANNELS];
`endif
  logic             sel_ok;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    chan_state_e st;

    pwm_capture_chan #(
      .CNT_W      (CNT_W),
      .TIMEOUT    (TIMEOUT),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .pwm_i    (pwm_in[g]),
      .clr_i    (clr),
      .high_o   (high_w[g]),
      .period_o (period_w[g]),
`ifdef PWM_CAPTURE_MINMAX_EN
      .hmin_o   (hmin_w[g]),
      .hmax_o   (hmax_w[g]),
`endif
      .stb_o    (meas_stb[g]),
      .valid_o  (meas_valid[g]),
      .timeout_o(timeout[g]),
      .level_o  (level[g]),
      .state_o  (st)
    );

    assign chan_state[g*STATE_W +: STATE_W] = st;
  end

  // Selects past the last channel read back as zero
  assign sel_ok = ({{(32-SEL_W){1'b0}}, rd_sel} < 32'(CHANNELS));

  // Registered read-back of the selected channel's published values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_high   <= '0;
      rd_period <= '0;
`ifdef PWM_CAPTURE_MINMAX_EN
      rd_hmin   <= '0;
      rd_hmax   <= '0;
`endif
    end else if (sel_ok) begin
      rd_high   <= high_w[rd_sel];
      rd_period <= period_w[rd_sel];
`ifdef PWM_CAPTURE_MINMAX_EN
      rd_hmin   <= hmin_w[rd_sel];
      rd_hmax   <= hmax_w[rd_sel];
`endif
    end else begin
      rd_high   <= '0;
      rd_period <= '0;
`ifdef PWM_CAPTURE_MINMAX_EN
      rd_hmin   <= '0;
      rd_hmax   <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_pwm_capture_multi.sv
// Directed bench for pwm_capture_multi (4 channels, TIMEOUT=5000).
// PWM waveforms are generated cycle by cycle from per-channel period/high
// tables; strobes, rise times and coincident strobes are tallied as they go.
module tb_pwm_capture_multi;

  localparam int CH  = 4;
  localparam int CW  = 20;
  localparam int TMO = 5000;

  logic            clk;
  logic            rst_n;
  logic [CH-1:0]   pwm_in;
  logic            clr;
  logic [1:0]      rd_sel;
  logic [CW-1:0]   rd_high;
  logic [CW-1:0]   rd_period;
`ifdef PWM_CAPTURE_MINMAX_EN
  logic [CW-1:0]   rd_hmin;
  logic [CW-1:0]   rd_hmax;
`endif
  logic [CH-1:0]   meas_stb;
  logic [CH-1:0]   meas_valid;
  logic [CH-1:0]   timeout;
  logic [CH-1:0]   level;
  logic [2*CH-1:0] chan_state;

  int n_cmp;
  int n_err;

  // waveform tables: per==0 means hold lvl
  int per [CH];
  int hi  [CH];
  int ph  [CH];
  bit lvl [CH];
  int stb_cnt [CH];
  int last_rise [CH];
  int last_stb [CH];
  int coin_cnt;
  int it_g;
  int clr_it;

  pwm_capture_multi #(
    .CHANNELS   (CH),
    .CNT_W      (CW),
    .TIMEOUT    (TMO),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_in    (pwm_in),
    .clr       (clr),
    .rd_sel    (rd_sel),
    .rd_high   (rd_high),
    .rd_period (rd_period),
`ifdef PWM_CAPTURE_MINMAX_EN
    .rd_hmin   (rd_hmin),
    .rd_hmax   (rd_hmax),
`endif
    .meas_stb  (meas_stb),
    .meas_valid(meas_valid),
    .timeout   (timeout),
    .level     (level),
    .chan_state(chan_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < CH; c++) stb_cnt[c] = 0;
    coin_cnt = 0;
  endtask

  // driver: one iteration per negedge; inputs driven and outputs sampled there
  task automatic drive(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      it_g++;
      for (int c = 0; c < CH; c++) begin
        bit nv;
        if (per[c] > 0) begin
          nv = (ph[c] < hi[c]);
          ph[c] = (ph[c] + 1) % per[c];
        end else begin
          nv = lvl[c];
        end
        if (nv && !pwm_in[c]) last_rise[c] = it_g;
        pwm_in[c] = nv;
        if (meas_stb[c]) begin
          stb_cnt[c]++;
          last_stb[c] = it_g;
        end
      end
      if (meas_stb == 4'hF) coin_cnt++;
      clr = (it_g == clr_it);
    end
  endtask

  initial begin
    int d;
    n_cmp = 0; n_err = 0; it_g = 0; clr_it = -1;
    for (int c = 0; c < CH; c++) begin
      per[c] = 0; hi[c] = 0; ph[c] = 0; lvl[c] = 1'b0;
      last_rise[c] = 0; last_stb[c] = 0;
    end
    clear_counts();
    rst_n = 1'b0; pwm_in = '0; clr = 1'b0; rd_sel = 2'd0;

    // ---- 1. reset values, then reset mid-pulse
    drive(3);
    check("rst_rd_high", rd_high, 0);
    check("rst_rd_period", rd_period, 0);
    check("rst_stb", meas_stb, 0);
    check("rst_valid", meas_valid, 0);
    check("rst_timeout", timeout, 0);
    check("rst_level", level, 0);
    check("rst_state", chan_state, 0);
    rst_n = 1'b1;
    per[0] = 300; hi[0] = 100; ph[0] = 0;
    drive(700);
    check("t1_stb_cnt", stb_cnt[0], 2);
    check("t1_high", rd_high, 100);
    check("t1_period", rd_period, 300);
    check("t1_valid", meas_valid, 4'b0001);
    drive(250);
    check("t1_level_pre", level, 4'b0001);
    rst_n = 1'b0;
    #1;
    check("t1_mid_valid", meas_valid, 0);
    check("t1_mid_level", level, 0);
    check("t1_mid_state", chan_state, 0);
    check("t1_mid_rd_high", rd_high, 0);
    check("t1_mid_stb", meas_stb, 0);
    drive(5);
    rst_n = 1'b1;
    clear_counts();
    drive(245);
    check("t1_no_stb", stb_cnt[0], 0);
    check("t1_state_low", chan_state[1:0], 2);
    check("t1_valid0", meas_valid[0], 0);
    drive(10);
    check("t1_first_stb", stb_cnt[0], 1);
    check("t1_valid1", meas_valid[0], 1);
    drive(300);
    check("t1_high2", rd_high, 100);
    check("t1_period2", rd_period, 300);

    // ---- 2. ch0 300 high / 700 low
    per[0] = 1000; hi[0] = 300; ph[0] = 0;
    drive(2100);
    clear_counts();
    drive(3000);
    check("t2_stb_cnt", stb_cnt[0], 3);
    check("t2_high", rd_high, 300);
    check("t2_period", rd_period, 1000);
    check("t2_latency", last_stb[0] - last_rise[0], 4);
    check("t2_timeout0", timeout[0], 0);

    // ---- 3. ch1 stuck high, then resumes
    check("t3_idle_timeout", timeout[1], 1);
    lvl[1] = 1'b1;
    drive(20);
    check("t3_tmo_clear", timeout[1], 0);
    check("t3_level_a", level[1], 1);
    drive(TMO + 10 - 20);
    check("t3_tmo_set", timeout[1], 1);
    check("t3_level_b", level[1], 1);
    check("t3_state_wait", chan_state[3:2], 0);
    per[1] = 200; hi[1] = 50; ph[1] = 50;
    clear_counts();
    drive(20);
    check("t3_tmo_clear2", timeout[1], 0);
    check("t3_state_wait2", chan_state[3:2], 0);
    check("t3_valid_low", meas_valid[1], 0);
    drive(330);
    check("t3_no_stb", stb_cnt[1], 0);
    drive(10);
    check("t3_one_stb", stb_cnt[1], 1);
    rd_sel = 2'd1;
    drive(2);
    check("t3_high", rd_high, 50);
    check("t3_period", rd_period, 200);

    // ---- 4. four channels, period 2000, duties 10/50/90/1 %
    for (int c = 0; c < CH; c++) begin
      per[c] = 2000; ph[c] = 0;
    end
    hi[0] = 200; hi[1] = 1000; hi[2] = 1800; hi[3] = 20;
    drive(4100);
    clear_counts();
    drive(4000);
    check("t4_stb0", stb_cnt[0], 2);
    check("t4_stb1", stb_cnt[1], 2);
    check("t4_stb2", stb_cnt[2], 2);
    check("t4_stb3", stb_cnt[3], 2);
    check("t4_coincident", coin_cnt, 2);
    for (int c = 0; c < CH; c++) begin
      rd_sel = 2'(c);
      drive(2);
      check($sformatf("t4_high_ch%0d", c), rd_high, 64'(hi[c]));
      check($sformatf("t4_period_ch%0d", c), rd_period, 2000);
    end

    // ---- 5. clr in the same cycle as a ch2 publish
    per[0] = 0; per[1] = 0; per[3] = 0;
    hi[2] = 700;
    drive(4100);
    d = (per[2] - ph[2]) % per[2];
    clr_it = it_g + 1 + d + 3;
    clear_counts();
    drive(clr_it + 10 - it_g);
    check("t5_valid", meas_valid, 4'b0100);
    check("t5_stb2", stb_cnt[2], 1);
    check("t5_stb0", stb_cnt[0], 0);
    rd_sel = 2'd2;
    drive(2);
    check("t5_high", rd_high, 700);
    check("t5_period", rd_period, 2000);
`ifdef PWM_CAPTURE_MINMAX_EN
    check("t5_hmin", rd_hmin, 700);
    check("t5_hmax", rd_hmax, 700);
`endif

    // ---- 6. ch0 highs 100, 400, 250 after a clr
    per[2] = 0;
    rd_sel = 2'd0;
    per[0] = 1000; hi[0] = 100; ph[0] = 0;
    drive(500);
    clr_it = it_g + 1;
    drive(2);
    check("t6_clr_valid", meas_valid, 0);
    drive(498);
    hi[0] = 400;
    drive(1000);
    hi[0] = 250;
    drive(1000);
    per[0] = 0; lvl[0] = 1'b1;
    drive(10);
    check("t6_high", rd_high, 250);
    check("t6_period", rd_period, 1000);
    check("t6_valid", meas_valid, 4'b0001);
`ifdef PWM_CAPTURE_MINMAX_EN
    check("t6_hmin", rd_hmin, 100);
    check("t6_hmax", rd_hmax, 400);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
